// File: rtl/io_display_pkg.sv
// io_display_pkg: shared FSM states, segment codes and decimal limits for io_hex_display.
package io_display_pkg;
    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    // Active-low gfedcba codes for 0..9; non-BCD nibbles decode to blank.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK
    };

    localparam logic [31:0] DEC_LIMIT_U = 32'd100000000;
    localparam logic [31:0] DEC_LIMIT_S = 32'd10000000;
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational 4-bit BCD to active-low 7-segment decoder.
module bcd_to_seg7
    import io_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[bcd];
endmodule

// File: rtl/io_hex_display.sv
// io_hex_display: shows an output-port word in decimal on HEX7..HEX0 via a sequential double-dabble.
// Macro HEX_SIGNED_EN: treat the word as two's complement, hex7 becomes the sign position.
module io_hex_display
    import io_display_pkg::*;
#(
    parameter int CONV_BITS = 32
) (
    input  logic        io_clk,
    input  logic        clr,
    input  logic [31:0] port_value,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7,
    output logic        busy,
    output logic        ovf
);
    localparam logic [5:0] LAST = 6'(CONV_BITS - 1);

    state_t      state, state_nx;
    logic [31:0] shown, cap, opnd, mag_in, mag_cap, limit;
    logic [39:0] bcd, bcd_adj;
    logic [5:0]  cnt;
    logic [7:0]  blank;
    logic [6:0]  seg [8];
    logic [6:0]  disp [8];
    logic [6:0]  hex_r [8];

`ifdef HEX_SIGNED_EN
    // Unsigned negation keeps -2^31 as 2147483648.
    assign mag_in  = port_value[31] ? -port_value : port_value;
    assign mag_cap = cap[31] ? -cap : cap;
    assign limit   = DEC_LIMIT_S;
`else
    assign mag_in  = port_value;
    assign mag_cap = cap;
    assign limit   = DEC_LIMIT_U;
`endif

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 10; i++)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    // A position blanks when it and every more significant digit (incl. overflow digits) is zero.
    assign blank[0] = 1'b0;
    for (genvar g = 1; g < 8; g++) begin : g_blank
        assign blank[g] = ~|bcd[39:4*g];
    end

    for (genvar g = 0; g < 8; g++) begin : g_dec
        bcd_to_seg7 u_dec (.bcd(bcd[4*g +: 4]), .seg(seg[g]));
    end

    always_comb begin
        for (int i = 0; i < 8; i++) disp[i] = blank[i] ? SEG_BLANK : seg[i];
`ifdef HEX_SIGNED_EN
        disp[7] = cap[31] ? SEG_MINUS : SEG_BLANK;
`endif
    end

    always_comb begin
        state_nx = state == IDLE    ? (port_value != shown ? CONVERT : IDLE) :
                   state == CONVERT ? (cnt == LAST ? UPDATE : CONVERT) : IDLE;
    end

    always_ff @(posedge io_clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= '0;
            bcd   <= '0;
            opnd  <= '0;
            cap   <= '0;
            shown <= '0;
            ovf   <= 1'b0;
            for (int i = 0; i < 8; i++) hex_r[i] <= i == 0 ? SEG_TABLE[0] : SEG_BLANK;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx == CONVERT) begin
                cap  <= port_value;
                opnd <= mag_in;
                bcd  <= '0;
                cnt  <= '0;
            end else if (state == CONVERT) begin
                {bcd, opnd} <= {bcd_adj[38:0], opnd, 1'b0};
                cnt         <= cnt + 6'd1;
            end else if (state == UPDATE) begin
                shown <= cap;
                ovf   <= mag_cap >= limit;
                for (int i = 0; i < 8; i++) hex_r[i] <= disp[i];
            end
        end
    end

    assign busy = state != IDLE;
    assign {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0} =
        {hex_r[7], hex_r[6], hex_r[5], hex_r[4], hex_r[3], hex_r[2], hex_r[1], hex_r[0]};
endmodule

// File: tb/tb_io_hex_display.sv
// tb_io_hex_display: randomized and directed checks of io_hex_display against a decimal reference model.
module tb_io_hex_display;
    logic        io_clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] port_value = '0;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic        busy, ovf;
    logic [57:0] dut_out;
    int          checks = 0;
    int          errors = 0;

    always #5 io_clk = ~io_clk;

    io_hex_display dut (
        .io_clk(io_clk), .clr(clr), .port_value(port_value),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7),
        .busy(busy), .ovf(ovf)
    );

    assign dut_out = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0, busy, ovf};

    logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Reference: the shown value changes 33 edges after an idle-cycle capture.
    logic [31:0] m_shown = '0;
    logic [31:0] m_cap = '0;
    int          m_cnt = 0;

    always @(posedge io_clk or posedge clr) begin
        if (clr) begin
            m_shown = '0;
            m_cap   = '0;
            m_cnt   = 0;
        end else if (m_cnt == 0) begin
            if (port_value != m_shown) begin
                m_cap = port_value;
                m_cnt = 33;
            end
        end else begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_shown = m_cap;
        end
    end

    function automatic logic [57:0] expect_out(input logic [31:0] v, input logic b);
        longint     mag, p;
        logic       neg, o;
        logic [6:0] h [8];
        neg = 1'b0;
        mag = longint'(v);
`ifdef HEX_SIGNED_EN
        neg = v[31];
        if (neg) mag = 64'd4294967296 - longint'(v);
`endif
        p = 1;
        for (int i = 0; i < 8; i++) begin
            h[i] = (i > 0 && mag < p) ? 7'h7F : segtab[(mag / p) % 10];
            p = p * 10;
        end
`ifdef HEX_SIGNED_EN
        h[7] = neg ? 7'h3F : 7'h7F;
        o = mag >= 10000000;
`else
        o = mag >= 100000000;
`endif
        return {h[7], h[6], h[5], h[4], h[3], h[2], h[1], h[0], b, o};
    endfunction

    always @(negedge io_clk) begin
        checks++;
        if (dut_out !== expect_out(m_shown, m_cnt != 0)) begin
            errors++;
            $display("FAIL cycle_compare t=%0t got %h expected %h", $time, dut_out, expect_out(m_shown, m_cnt != 0));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge io_clk);
        #1;
    endtask

    logic [31:0] edges [8] = '{32'd99999999, 32'd100000000, 32'd9999999, 32'd10000000,
                               32'hFF676981, 32'hFF676980, 32'h80000000, 32'h7FFFFFFF};

    initial begin
        tick(3);
        clr = 1'b0;
        chk("reset_hex0", {25'd0, hex0}, 32'h40);
        chk("reset_hex7_1", {hex7, hex6, hex5, hex4}, {4{7'h7F}});
        chk("reset_hex3_1", {11'd0, hex3, hex2, hex1}, {11'd0, {3{7'h7F}}});
        chk("reset_flags", {30'd0, busy, ovf}, 32'd0);
        tick(5);
        chk("idle_no_conv", {31'd0, busy}, 32'd0);

        port_value = 32'd12345678;
        tick(1);
        chk("busy_rise", {31'd0, busy}, 32'd1);
        tick(32);
        chk("busy_k32", {31'd0, busy}, 32'd1);
        tick(1);
        chk("busy_fall", {31'd0, busy}, 32'd0);
`ifndef HEX_SIGNED_EN
        chk("d12345678_hi", {hex7, hex6, hex5, hex4}, {7'h79, 7'h24, 7'h30, 7'h19});
        chk("d12345678_lo", {hex3, hex2, hex1, hex0}, {7'h12, 7'h02, 7'h78, 7'h00});
        chk("d12345678_ovf", {31'd0, ovf}, 32'd0);
`else
        chk("s12345678_ovf", {31'd0, ovf}, 32'd1);
        chk("s12345678_hex7", {25'd0, hex7}, 32'h7F);
`endif

        port_value = 32'd7;
        tick(34);
        chk("d7_hex0", {25'd0, hex0}, 32'h78);
        chk("d7_hex1", {25'd0, hex1}, 32'h7F);
        port_value = 32'd0;
        tick(34);
        chk("d0_hex0", {25'd0, hex0}, 32'h40);
        chk("d0_hex7", {25'd0, hex7}, 32'h7F);

        port_value = 32'hFFFFFFFF;
        tick(34);
`ifndef HEX_SIGNED_EN
        chk("dmax_hi", {hex7, hex6, hex5, hex4}, {7'h10, 7'h19, 7'h10, 7'h02});
        chk("dmax_lo", {hex3, hex2, hex1, hex0}, {7'h78, 7'h24, 7'h10, 7'h12});
        chk("dmax_ovf", {31'd0, ovf}, 32'd1);
`else
        chk("sneg1_hex7", {25'd0, hex7}, 32'h3F);
        chk("sneg1_hex0", {25'd0, hex0}, 32'h79);
        chk("sneg1_hex1", {25'd0, hex1}, 32'h7F);
        chk("sneg1_ovf", {31'd0, ovf}, 32'd0);
`endif

        port_value = 32'd5;
        tick(10);
        port_value = 32'd9;
        tick(24);
        chk("late_first", {25'd0, hex0}, 32'h12);
        chk("late_idle", {31'd0, busy}, 32'd0);
        tick(1);
        chk("late_recapture", {31'd0, busy}, 32'd1);
        tick(33);
        chk("late_second", {25'd0, hex0}, 32'h10);

        port_value = 32'd12345;
        tick(20);
        clr = 1'b1;
        #1;
        chk("abort_hex0", {25'd0, hex0}, 32'h40);
        chk("abort_hex1", {25'd0, hex1}, 32'h7F);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        tick(2);
        clr = 1'b0;
        tick(34);
        chk("reconv_hex0", {25'd0, hex0}, 32'h12);
        chk("reconv_hex4", {25'd0, hex4}, 32'h79);
        chk("reconv_hex5", {25'd0, hex5}, 32'h7F);

        for (int it = 0; it < 250; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3) port_value = $urandom_range(0, 999);
            else if (r < 5) port_value = $urandom_range(0, 199999999);
            else if (r < 7) port_value = edges[$urandom_range(0, 7)];
            else if (r == 7) port_value = 32'd0;
            else port_value = $urandom;
            if ($urandom_range(0, 19) == 0) begin
                tick($urandom_range(1, 40));
                clr = 1'b1;
                tick(1);
                clr = 1'b0;
            end
            tick($urandom_range(1, 80));
        end
        tick(70);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
